// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the RV64 opcode/funct constants for the supported subset (ld, sd, add, sub),
// the one-hot state encoding, the ALU operation encodings and the instruction-class enum.
package control_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_ADDSUB  = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_DECODE    = 5'b00010,
    ST_EXECUTE   = 5'b00100,
    ST_MEM       = 5'b01000,
    ST_WRITEBACK = 5'b10000
  } state_t;

  typedef enum logic [2:0] {
    CLS_LD,
    CLS_SD,
    CLS_ADD,
    CLS_SUB,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder.
// Maps the instruction register to its class, register fields and sign-extended immediate.
// Ports: ir (instruction word) -> cls, rs1, rs2, rd, imm (I-type for ld, S-type for sd, else 0).
module instr_decoder
  import control_unit_pkg::*;
#(
  parameter int WORDSIZE   = 64,
  parameter int SIZE       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [SIZE-1:0]       ir,
  output instr_class_t          cls,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [WORDSIZE-1:0]   imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = ir[31:20];
  assign imm_s  = {ir[31:25], ir[11:7]};

  always_comb begin
    cls = CLS_ILLEGAL;
    imm = '0;
    if (opcode == OPC_LOAD && funct3 == F3_DWORD) begin
      cls = CLS_LD;
      imm = {{(WORDSIZE-12){imm_i[11]}}, imm_i};
    end else if (opcode == OPC_STORE && funct3 == F3_DWORD) begin
      cls = CLS_SD;
      imm = {{(WORDSIZE-12){imm_s[11]}}, imm_s};
    end else if (opcode == OPC_OP && funct3 == F3_ADDSUB) begin
      if (funct7 == F7_ADD)      cls = CLS_ADD;
      else if (funct7 == F7_SUB) cls = CLS_SUB;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the register-file / ALU / data-memory datapath.
// Accepts one instruction per valid/ready handshake and sequences decode, execute,
// memory and writeback for ld, sd, add and sub.
// Ports: clk, reset (async, active-high); instr_valid/instr_ready/instruction handshake;
// dm_ready from data memory; register-file, ALU and data-memory control outputs;
// done / illegal / mem_timeout one-cycle status pulses.
// Optional: define CONTROL_UNIT_PERF_EN to add saturating perf_retired / perf_stall counters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for instr_valid; IR latched on acceptance
// DECODE    | register addresses driven; illegal instructions flagged
// EXECUTE   | ALU controls and immediate driven; timeout counter cleared
// MEM       | dm_read / dm_write_enable held until dm_ready or timeout
// WRITEBACK | register-file write (suppressed for rd = x0), done pulse
module multicycle_control_unit
  import control_unit_pkg::*;
#(
  parameter int WORDSIZE    = 64,
  parameter int SIZE        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [SIZE-1:0]       instruction,
  input  logic                  dm_ready,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic                  rf_wb_sel,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  alu_src_imm,
  output logic [WORDSIZE-1:0]   imm,
  output logic                  dm_read,
  output logic                  dm_write_enable,
  output logic                  done,
  output logic                  illegal,
`ifdef CONTROL_UNIT_PERF_EN
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_stall,
`endif
  output logic                  mem_timeout
);

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  state_t                state, state_nxt;
  logic [SIZE-1:0]       ir;
  logic [7:0]            tmo_cnt;
  instr_class_t          cls;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [WORDSIZE-1:0]   imm_dec;
  logic                  is_mem;
  logic                  tmo_hit;

  instr_decoder #(
    .WORDSIZE  (WORDSIZE),
    .SIZE      (SIZE),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_dec (
    .ir (ir),
    .cls(cls),
    .rs1(rs1),
    .rs2(rs2),
    .rd (rd),
    .imm(imm_dec)
  );

  assign is_mem  = (cls == CLS_LD) || (cls == CLS_SD);
  // Abort is taken on the cycle after the last allowed stall, so the strobe
  // is seen for exactly MEM_TIMEOUT stalled cycles.
  assign tmo_hit = (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir      <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == ST_IDLE && instr_valid) ir <= instruction;
      if (state == ST_EXECUTE)
        tmo_cnt <= '0;
      else if (state == ST_MEM && !dm_ready && !tmo_hit)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt       = state;
    instr_ready     = 1'b0;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_wb_sel       = 1'b0;
    alu_op          = '0;
    alu_src_imm     = 1'b0;
    imm             = '0;
    dm_read         = 1'b0;
    dm_write_enable = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    mem_timeout     = 1'b0;

    if (state != ST_IDLE) begin
      rf_addr_a = rs1;
      rf_addr_b = rs2;
    end
    if (state inside {ST_EXECUTE, ST_MEM, ST_WRITEBACK}) begin
      alu_op      = (cls == CLS_SUB) ? ALU_OP_W'(ALU_SUB) : ALU_OP_W'(ALU_ADD);
      alu_src_imm = is_mem;
      imm         = imm_dec;
    end

    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          illegal   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_nxt = is_mem ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        if (tmo_hit) begin
          mem_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          dm_read         = (cls == CLS_LD);
          dm_write_enable = (cls == CLS_SD);
          if (dm_ready) begin
            if (cls == CLS_LD) begin
              state_nxt = ST_WRITEBACK;
            end else begin
              done      = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_WRITEBACK: begin
        rf_write_addr   = rd;
        rf_wb_sel       = (cls == CLS_LD);
        rf_write_enable = (rd != '0);
        done            = 1'b1;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CONTROL_UNIT_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (done && perf_retired != '1)
        perf_retired <= perf_retired + 32'd1;
      if (state == ST_MEM && !dm_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        dm_ready;
  logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
  logic        rf_write_enable, rf_wb_sel;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic [63:0] imm;
  logic        dm_read, dm_write_enable, done, illegal, mem_timeout;
`ifdef CONTROL_UNIT_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  int n_total = 0;
  int n_bad   = 0;

  multicycle_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .dm_ready       (dm_ready),
    .rf_addr_a      (rf_addr_a),
    .rf_addr_b      (rf_addr_b),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr  (rf_write_addr),
    .rf_wb_sel      (rf_wb_sel),
    .alu_op         (alu_op),
    .alu_src_imm    (alu_src_imm),
    .imm            (imm),
    .dm_read        (dm_read),
    .dm_write_enable(dm_write_enable),
    .done           (done),
    .illegal        (illegal),
`ifdef CONTROL_UNIT_PERF_EN
    .perf_retired   (perf_retired),
    .perf_stall     (perf_stall),
`endif
    .mem_timeout    (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Sample point for the next cycle: the falling edge after the next rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Offer an instruction from a falling edge; it is accepted at the next rising edge (T0).
  // Returns just after T0, so the next step() lands in cycle 1 after T0.
  task automatic offer(input logic [31:0] word);
    instr_valid = 1'b1;
    instruction = word;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 32'hFFFF_FFFF;
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    dm_ready    = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", rf_write_enable, 0);
    chk("rst_strobes", {dm_read, dm_write_enable, illegal, mem_timeout}, 0);
    chk("rst_imm", imm, 0);
    reset = 1'b0;
    step();
    chk("idle_hold", instr_ready, 1);

    // add x3,x1,x2
    offer(32'h002081B3);
    step();
    chk("add_d_ready", instr_ready, 0);
    chk("add_d_addr", {rf_addr_a, rf_addr_b}, {5'd1, 5'd2});
    step();
    chk("add_e_alu", {alu_op, alu_src_imm}, {2'd0, 1'b0});
    chk("add_e_done", done, 0);
    step();
    chk("add_w", {rf_write_enable, rf_write_addr, rf_wb_sel, done}, {1'b1, 5'd3, 1'b0, 1'b1});
    step();
    chk("add_idle", {instr_ready, done, rf_write_enable}, {1'b1, 1'b0, 1'b0});

    // sub x5,x6,x7
    offer(32'h407302B3);
    step();
    chk("sub_d_addr", {rf_addr_a, rf_addr_b}, {5'd6, 5'd7});
    step();
    chk("sub_e_alu", alu_op, 1);
    step();
    chk("sub_w", {rf_write_enable, rf_write_addr, done, alu_op}, {1'b1, 5'd5, 1'b1, 2'd1});
    step();

    // ld x4,-8(x2) with two stall cycles
    offer(32'hFF813203);
    step();
    chk("ld_d_addr", rf_addr_a, 2);
    chk("ld_d_read", dm_read, 0);
    step();
    chk("ld_e_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ld_e_src", alu_src_imm, 1);
    step();
    chk("ld_m1_read", {dm_read, dm_write_enable, done}, {1'b1, 1'b0, 1'b0});
    step();
    chk("ld_m2_read", {dm_read, done}, {1'b1, 1'b0});
    step();
    dm_ready = 1'b1;
    #1;
    chk("ld_m3_read", {dm_read, done}, {1'b1, 1'b0});
    step();
    dm_ready = 1'b0;
    chk("ld_w", {rf_write_enable, rf_wb_sel, rf_write_addr, done, dm_read},
        {1'b1, 1'b1, 5'd4, 1'b1, 1'b0});
    chk("ld_w_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
`ifdef CONTROL_UNIT_PERF_EN
    chk("ld_perf_stall", perf_stall, 2);
    chk("ld_perf_retired", perf_retired, 2);
`endif
    step();
    chk("ld_idle", instr_ready, 1);

    // sd x9,16(x10) with immediate completion
    dm_ready = 1'b1;
    offer(32'h00953823);
    step();
    chk("sd_d_addr", {rf_addr_a, rf_addr_b}, {5'd10, 5'd9});
    chk("sd_d_we", dm_write_enable, 0);
    step();
    chk("sd_e_imm", imm, 64'd16);
    chk("sd_e_src", alu_src_imm, 1);
    step();
    chk("sd_m", {dm_write_enable, done, rf_write_enable, dm_read}, {1'b1, 1'b1, 1'b0, 1'b0});
    step();
    dm_ready = 1'b0;
    chk("sd_idle", {instr_ready, done, dm_write_enable}, {1'b1, 1'b0, 1'b0});

    // illegal instruction
    offer(32'h0000007F);
    step();
    chk("ill_d", {illegal, dm_read, dm_write_enable, rf_write_enable, done}, 5'b10000);
    step();
    chk("ill_idle", {instr_ready, illegal}, {1'b1, 1'b0});

    // add x0,x1,x2: retires without a register write
    offer(32'h00208033);
    repeat (3) step();
    chk("x0_w", {done, rf_write_enable}, {1'b1, 1'b0});
    step();

    // ld with dm_ready stuck low
    offer(32'hFF813203);
    repeat (2) step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("tmo_m%0d", i), {dm_read, mem_timeout, done}, {1'b1, 1'b0, 1'b0});
    end
    step();
    chk("tmo_abort", {mem_timeout, dm_read, done}, {1'b1, 1'b0, 1'b0});
    step();
    chk("tmo_idle", {instr_ready, mem_timeout, done}, {1'b1, 1'b0, 1'b0});

    // reset while an add is in EXECUTE
    offer(32'h002081B3);
    step();
    step();
    chk("rst_mid_exec", instr_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_now", {instr_ready, rf_write_enable, done, rf_addr_a}, {1'b1, 1'b0, 1'b0, 5'd0});
    step();
    reset = 1'b0;
    step();
    chk("rst_mid_after", {instr_ready, rf_write_enable, done}, {1'b1, 1'b0, 1'b0});
`ifdef CONTROL_UNIT_PERF_EN
    chk("rst_perf", {perf_retired, perf_stall}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle control FSM for the register-file/ALU/data-memory datapath.
- Accepts one 32-bit RV64 instruction per valid/ready handshake and sequences decode, execute, memory and writeback.
- Supports ld, sd, add and sub, with a memory stall handshake, a memory timeout, illegal-instruction reporting and rd=x0 write suppression.
- All state advances on the rising clock edge only.

Parameters:
- WORDSIZE, 64, datapath width; immediate output is sign-extended to this width.
- SIZE, 32, instruction width.
- REG_ADDR_W, 5, register-file address width.
- ALU_OP_W, 2, alu_op width.
- MEM_TIMEOUT, 16, maximum MEM cycles with dm_ready low before abort; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instruction  in  SIZE  instruction word
- dm_ready  in  1  data memory completes the access this cycle
- rf_addr_a  out  REG_ADDR_W  rs1
- rf_addr_b  out  REG_ADDR_W  rs2
- rf_write_enable  out  1  register-file write strobe
- rf_write_addr  out  REG_ADDR_W  rd
- rf_wb_sel  out  1  writeback source: 0 = ALU, 1 = memory
- alu_op  out  ALU_OP_W  ALU operation: 0 = ADD, 1 = SUB
- alu_src_imm  out  1  ALU operand B is imm (1) or rf b (0)
- imm  out  WORDSIZE  sign-extended immediate
- dm_read  out  1  data-memory read request
- dm_write_enable  out  1  data-memory write request
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse when an instruction is not decodable
- mem_timeout  out  1  one-cycle pulse when a memory access is aborted

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state goes to IDLE and the instruction register (IR) clears to 0.
  - the timeout counter clears to 0.
  - every output is 0 except instr_ready, which is 1.
- Reset mid-instruction abandons the instruction; no write or done is issued.
- States: IDLE, DECODE, EXECUTE, MEM, WRITEBACK.
- Outputs are decoded from the registered state and IR (Moore), except done in MEM for stores.
- IDLE:
  - instr_ready=1.
  - instr_valid=1 at a posedge latches IR and moves to DECODE.
  - instruction is ignored at any other time.
- Decode:
  - ld: opcode 0000011, funct3 011.
  - sd: opcode 0100011, funct3 011.
  - add: opcode 0110011, funct3 000, funct7 0000000.
  - sub: opcode 0110011, funct3 000, funct7 0100000.
  - Anything else is illegal.
- DECODE:
  - rf_addr_a=IR[19:15], rf_addr_b=IR[24:20]; these hold until the state returns to IDLE.
  - Illegal instruction: illegal=1 for this cycle, then IDLE.
  - Otherwise move to EXECUTE.
- EXECUTE:
  - alu_op=SUB for sub, ADD otherwise.
  - alu_src_imm=1 for ld/sd.
  - imm: I-type IR[31:20] for ld; S-type {IR[31:25],IR[11:7]} for sd; sign-extended to WORDSIZE.
  - add/sub move to WRITEBACK; ld/sd move to MEM with the timeout counter cleared.
- MEM:
  - ld: dm_read=1. sd: dm_write_enable=1. The strobe holds every cycle until dm_ready=1.
  - dm_ready=1 with ld: move to WRITEBACK.
  - dm_ready=1 with sd: done=1 in the same cycle, then IDLE.
  - dm_ready=0: the counter increments.
  - When the counter reaches MEM_TIMEOUT: mem_timeout=1, strobes drop, move to IDLE, no done.
- WRITEBACK:
  - rf_write_addr=IR[11:7].
  - rf_wb_sel=1 for ld, 0 for add/sub.
  - rf_write_enable=1 unless rd=0.
  - done=1, then IDLE.
- Latency, with T0 = acceptance edge:
  - add/sub: done in the 3rd cycle after T0 (DECODE, EXECUTE, WRITEBACK).
  - ld with zero stall: 4th cycle. sd with zero stall: 3rd cycle.
  - Each stall cycle adds 1.
  - Throughput is one instruction per full sequence; there is no overlap.
- alu_op, alu_src_imm, imm and the rf addresses stay stable from EXECUTE through retirement.

Optional Feature:
- CONTROL_UNIT_PERF_EN defined: adds outputs perf_retired[31:0] and perf_stall[31:0].
  - perf_retired counts done pulses.
  - perf_stall counts MEM cycles with dm_ready=0.
  - Both saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package control_unit_pkg holds:
  - opcode/funct3/funct7 constants;
  - state encoding (one-hot, 5 bits);
  - ALU_ADD and ALU_SUB encodings;
  - instruction class enum: LD, SD, ADD, SUB, ILLEGAL.
- Sub-module instr_decoder is purely combinational. It maps IR to class, rs1, rs2, rd and the sign-extended imm; the FSM instantiates it once.

Test Plan:
- add x3,x1,x2 (0x002081B3):
  - DECODE: rf_addr_a=1, rf_addr_b=2.
  - EXECUTE: alu_op=0, alu_src_imm=0.
  - 3rd cycle after T0: rf_write_enable=1, rf_write_addr=3, rf_wb_sel=0, done=1.
- sub x5,x6,x7 (0x407302B3): alu_op=1; writeback to rd 5; done in the 3rd cycle after T0.
- ld x4,-8(x2) (0xFF813203) with dm_ready held low 2 cycles:
  - imm=0xFFFFFFFFFFFFFFF8, dm_read high for 3 cycles.
  - Then rf_write_enable=1, rf_wb_sel=1, rf_write_addr=4; done in the 6th cycle after T0; perf_stall=2 when CONTROL_UNIT_PERF_EN is defined.
- sd x9,16(x10) (0x00953823) with dm_ready=1 immediately: imm=16, rf_addr_a=10, rf_addr_b=9; dm_write_enable and done both high in the 3rd cycle after T0; no rf write.
- 0x0000007F: illegal=1 in DECODE, no strobes, instr_ready=1 the next cycle. Separately, add x0,x1,x2 (0x00208033): done=1 with rf_write_enable=0.
- ld with dm_ready stuck at 0, MEM_TIMEOUT=16: mem_timeout pulses after 16 MEM cycles, dm_read drops, no done. Separately, asserting reset in the EXECUTE state of an add returns the block to IDLE immediately with no write.
